// File: rtl/serial_add_pkg.sv
// Shared constants and helpers for the bit-serial add scheduler.
// State encodings, requester ids and the full-adder carry function.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_datapath.sv
// Bit-serial adder: operand shift registers, carry flop, result collection.
// Bits are consumed LSB first; the sum is published only on the finish edge.
module serial_add_datapath
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic             finish,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic             carry_out_reg;
  logic             sum_bit;
  logic             carry_next;

  assign sum_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign carry_next = maj(a_sr_reg[0], b_sr_reg[0], carry_reg);

  // Only the upper WIDTH-1 sum bits need storing; the newest bit comes straight from sum_bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_next = sum_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] res_sr_reg;
      assign res_next = {sum_bit, res_sr_reg};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_sr_reg <= '0;
        end else if (load) begin
          res_sr_reg <= '0;
        end else if (shift_en) begin
          res_sr_reg <= res_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      carry_reg <= 1'b0;
    end else if (load) begin
      a_sr_reg  <= a_in;
      b_sr_reg  <= b_in;
      carry_reg <= 1'b0;
    end else if (shift_en) begin
      a_sr_reg  <= a_sr_reg >> 1;
      b_sr_reg  <= b_sr_reg >> 1;
      carry_reg <= carry_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
    end else if (shift_en && finish) begin
      result_reg    <= res_next;
      carry_out_reg <= carry_next;
    end
  end

  assign result    = result_reg;
  assign carry_out = carry_out_reg;

endmodule

// File: rtl/serial_add_scheduler.sv
// Two-requester round-robin front end for a shared bit-serial adder.
// Holds the FSM, bit counter, arbiter and operand mux; arithmetic lives in the datapath.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic             owner_reg;
  logic             last_served_reg;
  logic             grant;
  logic             capture;
  logic             last_bit;
  logic             shift_en;
  logic             finish;
  logic             done_st;
  logic [1:0]       ack_vec;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  assign last_bit = (count_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    state_next = state_reg;
    grant      = REQ0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) begin
          capture    = 1'b1;
          state_next = ST_SHIFT;
          if (req0 && req1) begin
            grant = ~last_served_reg;
          end else begin
            grant = req1 ? REQ1 : REQ0;
          end
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    done_st  = 1'b0;
    case (state_reg)
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        finish   = last_bit;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done_st = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg       <= '0;
      owner_reg       <= 1'b0;
      last_served_reg <= 1'b1;
    end else begin
      if (capture) begin
        count_reg <= '0;
        owner_reg <= grant;
      end else if (shift_en) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      if (done_st) begin
        last_served_reg <= owner_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = done_st && (owner_reg == 1'(gi));
    end
  endgenerate

  assign ack0  = ack_vec[0];
  assign ack1  = ack_vec[1];
  assign owner = owner_reg;

  assign a_sel = (grant == REQ1) ? a1 : a0;
  assign b_sel = (grant == REQ1) ? b1 : b0;

  serial_add_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .shift_en (shift_en),
    .finish   (finish),
    .a_in     (a_sel),
    .b_in     (b_sel),
    .result   (result),
    .carry_out(carry_out)
  );

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench: vector table of single operations plus hand-written
// arbitration, operand-change, reset-abort and back-to-back sequences.
module tb_serial_add_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         ack0;
  logic         ack1;
  logic         busy;
  logic         owner;
  logic [W-1:0] result;
  logic         carry_out;

  serial_add_scheduler #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .ack0     (ack0),
    .ack1     (ack1),
    .busy     (busy),
    .owner    (owner),
    .result   (result),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cy;
  } exp_t;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cy;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      req1 = 1'b1; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b;
    end
  endtask

  // Counts negedges until the given ack is seen; cyc is measured from the call.
  task automatic wait_ack(input logic id, output int cyc, output int busy_cnt);
    bit seen;
    seen = 0;
    cyc = 0;
    busy_cnt = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (id ? ack1 : ack0) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: id=%0d no ack after %0d cycles", id, cyc);
    end
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] sum, input logic cy);
    int cyc, bc;
    @(negedge clk);
    set_req(id, a, b);
    sb_q.push_back('{id: id, sum: sum, cy: cy});
    wait_ack(id, cyc, bc);
    check("ack_latency", cyc, 5);
    check("busy_cycles", bc, 5);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    $display("op id=%0d a=%b b=%b -> result=%b carry=%b", id, a, b, result, carry_out);
  endtask

  // Scoreboard monitor: every ack pops one expected record; results must hold otherwise.
  initial begin
    exp_t         e;
    logic [W-1:0] prev_res;
    logic         prev_cy;
    logic         prev_ok;
    prev_ok = 1'b0;
    prev_res = '0;
    prev_cy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack0 && ack1) check("ack_exclusive", 2'b11, 2'b00);
        if (ack0 || ack1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_ack", {ack1, ack0}, 2'b00);
          end else begin
            e = sb_q.pop_front();
            check("ack_id", ack1, e.id);
            check("owner", owner, e.id);
            check("result", result, e.sum);
            check("carry_out", carry_out, e.cy);
          end
        end else if (prev_ok) begin
          check("result_hold", {carry_out, result}, {prev_cy, prev_res});
        end
      end
      prev_ok  = rst_n;
      prev_res = result;
      prev_cy  = carry_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc;
    logic [W-1:0] sa0, sb0, sa1, sb1;
    vecs[0] = '{id: 1'b0, a: 4'b0011, b: 4'b0101, sum: 4'b1000, cy: 1'b0};
    vecs[1] = '{id: 1'b1, a: 4'b1111, b: 4'b0001, sum: 4'b0000, cy: 1'b1};
    vecs[2] = '{id: 1'b0, a: 4'b1111, b: 4'b1111, sum: 4'b1110, cy: 1'b1};
    vecs[3] = '{id: 1'b1, a: 4'b0000, b: 4'b0000, sum: 4'b0000, cy: 1'b0};
    vecs[4] = '{id: 1'b0, a: 4'b1010, b: 4'b0101, sum: 4'b1111, cy: 1'b0};
    vecs[5] = '{id: 1'b1, a: 4'b1001, b: 4'b0111, sum: 4'b0000, cy: 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_owner", owner, 0);
    check("rst_result", {carry_out, result}, 0);
    rst_n = 1'b1;

    // Single-requester vectors
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cy);
    end

    // Operands changed after capture must be ignored
    @(negedge clk);
    set_req(1'b0, 4'b0001, 4'b0001);
    sb_q.push_back('{id: 1'b0, sum: 4'b0010, cy: 1'b0});
    @(negedge clk);
    check("capture_busy", busy, 1);
    a0 = 4'b1111;
    wait_ack(1'b0, cyc, bc);
    check("late_operand_latency", cyc, 4);
    req0 = 1'b0;
    $display("op id=0 a changed mid-op -> result=%b carry=%b", result, carry_out);

    // Reset in the middle of a req1 operation (count == 2)
    @(negedge clk);
    set_req(1'b1, 4'b0110, 4'b1010);
    repeat (3) @(negedge clk);
    check("pre_abort_owner", owner, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ack", {ack1, ack0}, 0);
    check("abort_owner", owner, 0);
    check("abort_result", {carry_out, result}, 0);
    $display("reset asserted mid-operation");
    req1 = 1'b0;

    // Both requesters held from reset release: grants alternate 0,1,0,1
    sa0 = 4'b0011; sb0 = 4'b0101; sa1 = 4'b1111; sb1 = 4'b0001;
    @(negedge clk);
    set_req(1'b0, sa0, sb0);
    set_req(1'b1, sa1, sb1);
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(k[0] ? exp_t'{id: 1'b1, sum: 4'b0000, cy: 1'b1}
                          : exp_t'{id: 1'b0, sum: 4'b1000, cy: 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(k[0], cyc, bc);
      check("rr_spacing", cyc, (k == 0) ? 5 : 6);
      $display("rr op %0d id=%0d -> result=%b carry=%b", k, k[0], result, carry_out);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // req1 alone after the abort
    do_op(1'b1, 4'b0110, 4'b0011, 4'b1001, 1'b0);

    // req1 held continuously for three operations
    @(negedge clk);
    set_req(1'b1, 4'b0101, 4'b0110);
    for (int k = 0; k < 3; k++) sb_q.push_back('{id: 1'b1, sum: 4'b1011, cy: 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, cyc, bc);
      check("b2b_spacing", cyc, (k == 0) ? 5 : 6);
      $display("b2b op %0d id=1 -> result=%b carry=%b", k, result, carry_out);
    end
    req1 = 1'b0;

    repeat (4) @(negedge clk);
    check("idle_after_all", busy, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
Controller and arbiter that shares one bit-serial add datapath between two requesters. It captures the winning requester's operands and sequences WIDTH shift/add cycles, LSB first, with a carry flip-flop. It then returns the sum and carry-out with a one-cycle acknowledge. It sits above the serial adder shift registers and replaces manual load/done sequencing at the top level.

Parameters:
WIDTH, 4, operand and result width in bits (>= 1)
CNT_W, $clog2(WIDTH+1), bit counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request; held until ack0
a0  in  WIDTH  requester 0 operand A
b0  in  WIDTH  requester 0 operand B
req1  in  1  requester 1 request; held until ack1
a1  in  WIDTH  requester 1 operand A
b1  in  WIDTH  requester 1 operand B
ack0  out  1  one-cycle pulse: requester 0 operation complete
ack1  out  1  one-cycle pulse: requester 1 operation complete
busy  out  1  high in SHIFT and DONE
owner  out  1  id of requester being served; valid while busy
result  out  WIDTH  sum of last completed operation
carry_out  out  1  carry-out of last completed operation

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; all shift registers, carry, count, result, carry_out, owner, ack0/ack1 and busy = 0.
  - last_served = 1, so req0 wins the first tie.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, it wins.
  - If both are pending, the requester != last_served wins (round-robin).
  - On the capture edge: load a_sr/b_sr from the winner's operands, carry = 0, count = 0, owner = winner, go to SHIFT.
- SHIFT, each edge:
  - s = a_sr[0]^b_sr[0]^carry
  - carry <= majority(a_sr[0], b_sr[0], carry)
  - res_sr <= {s, res_sr[WIDTH-1:1]}
  - a_sr, b_sr shift right one bit
  - count++
  - On the edge where count == WIDTH-1: result <= {s, res_sr[WIDTH-1:1]}, carry_out <= majority(...), go to DONE.
- DONE (exactly one cycle):
  - ack[owner] = 1.
  - last_served <= owner.
  - Next edge: go to IDLE.
- Timing: ack is visible WIDTH+1 cycles after the capture edge. A continuously requesting single source is acked every WIDTH+2 cycles.
- result and carry_out change only on the completion edge and hold until the next completion.
- Operands are sampled only at the capture edge; later changes on a*/b* are ignored.
- req is sampled only in IDLE:
  - A req still high in the cycle after ack is a new request.
  - A req dropped mid-operation does not abort it; ack still pulses.
- ack0 and ack1 are never high together; at most one is high per cycle.
- WIDTH = 1: SHIFT lasts one cycle; result = a^b, carry_out = a&b.
- Reset mid-operation: the operation is aborted, no ack is issued, result/carry_out are cleared, and last_served returns to 1.
- Arithmetic: modulo 2^WIDTH; the overflow bit appears only on carry_out.

Decomposition:
- Package serial_add_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2.
  - requester id constants REQ0 = 1'b0, REQ1 = 1'b1.
- One sub-module, serial_add_datapath (parameter WIDTH):
  - contents: a_sr, b_sr, res_sr, carry FF, result/carry_out registers.
  - inputs: load, shift_en, finish, a_in, b_in.
- The top level holds the FSM, bit counter, round-robin arbiter and operand mux.

Test Plan:
- Only req0, a0=0011, b0=0101, held until ack -> busy high 5 cycles; ack0 pulses 5 cycles after capture; result=1000, carry_out=0; ack1 stays 0.
- req1, a1=1111, b1=0001 -> result=0000, carry_out=1, owner=1, one ack1 pulse.
- req0 and req1 both high from reset release and held -> ack order 0,1,0,1, each ack 6 cycles apart; results match each requester's operands.
- Capture req0 with a0=0001, b0=0001, then set a0=1111 during SHIFT -> result=0010, carry_out=0 (the captured value is used).
- Pull rst_n low at SHIFT count=2 -> all outputs 0 immediately and no ack. After release, req1 alone with a1=0110, b1=0011 -> result=1001.
- Only req1 held continuously for 3 operations -> ack1 every 6 cycles, with no lockout from last_served=1.
